// File: rtl/ook_tx_pkg.sv
// ook_tx_pkg: shared state encoding, mode constants and width helper for the OOK frame transmitter
package ook_tx_pkg;
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;
  localparam logic MODE_NRZ = 1'b0;
  localparam logic MODE_MAN = 1'b1;
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ook_bit_timer.sv
// ook_bit_timer: symbol cycle counter with look-ahead half-symbol flag and carrier divider
module ook_bit_timer import ook_tx_pkg::*; #(
  parameter int BIT_CYCLES  = 1000,
  parameter int CARRIER_DIV = 0
)(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic lvl_n,
  output logic symbol_end,
  output logic second_half_n,
  output logic car_n
);
  localparam int CW = cw(BIT_CYCLES);
  localparam int DW = cw(CARRIER_DIV);
  logic [CW-1:0] cyc, cyc_n;
  logic [DW-1:0] cc, cc_n;
  logic half_point, second_q, lvl_q, ph, ph_n, rise, wrap;
  // Everything here is computed for the next cycle so the top can register ant_out
  always_comb begin
    symbol_end    = run && cyc == CW'(BIT_CYCLES - 1);
    half_point    = run && cyc == CW'(BIT_CYCLES / 2 - 1);
    cyc_n         = (run && !symbol_end) ? cyc + 1'b1 : '0;
    second_half_n = run && (half_point || (second_q && !symbol_end));
    rise          = lvl_n && !lvl_q;
    wrap          = cc == DW'(CARRIER_DIV - 1);
    cc_n          = (rise || !lvl_n || wrap) ? '0 : cc + 1'b1;
    ph_n          = rise ? 1'b1 : (lvl_n && wrap) ? ~ph : ph;
    car_n         = lvl_n && (CARRIER_DIV == 0 || ph_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc      <= '0;
      cc       <= '0;
      second_q <= 1'b0;
      lvl_q    <= 1'b0;
      ph       <= 1'b0;
    end else begin
      cyc      <= cyc_n;
      cc       <= cc_n;
      second_q <= second_half_n;
      lvl_q    <= lvl_n;
      ph       <= ph_n;
    end
  end
endmodule

// File: rtl/ook_frame_tx.sv
// ook_frame_tx: framed OOK/Manchester transmitter (preamble, payload MSB-first, even parity, idle gap)
module ook_frame_tx import ook_tx_pkg::*; #(
  parameter int               DATA_W      = 256,
  parameter int               PRE_W       = 8,
  parameter logic [PRE_W-1:0] PREAMBLE    = 8'hA5,
  parameter int               BIT_CYCLES  = 1000,
  parameter int               GAP_BITS    = 4,
  parameter int               CARRIER_DIV = 0
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              ant_out
);
  localparam int N  = PRE_W + DATA_W + 1 + GAP_BITS;
  localparam int SW = cw(N);
  localparam int SR = PRE_W + DATA_W;
  if (BIT_CYCLES < 2 || BIT_CYCLES % 2 != 0) begin : g_bad_bit_cycles
    $error("BIT_CYCLES must be even and at least 2");
  end
  state_t state, state_n;
  logic [SW-1:0] cnt, cnt_n;
  logic [SR-1:0] sh, sh_n;
  logic par, par_n, mode_q, mode_n, done_n, accept, last, bit_n, lvl_n;
  logic sym_end, second_n, car_n;
  assign data_ready = state == IDLE;
  assign busy       = state != IDLE;
  ook_bit_timer #(.BIT_CYCLES(BIT_CYCLES), .CARRIER_DIV(CARRIER_DIV)) u_timer (
    .clk(clk), .rst(reset), .run(busy), .lvl_n(lvl_n),
    .symbol_end(sym_end), .second_half_n(second_n), .car_n(car_n)
  );
  // Preamble and payload share one shift register; its MSB is always the bit on air
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    par_n   = par;
    mode_n  = mode_q;
    done_n  = 1'b0;
    accept  = data_valid && state == IDLE;
    last    = (state == PRE && cnt == SW'(PRE_W - 1)) || (state == DATA && cnt == SW'(DATA_W - 1)) ||
              state == PAR || (state == GAP && cnt == SW'(GAP_BITS - 1));
    if (accept) begin
      state_n = PRE;
      cnt_n   = '0;
      sh_n    = {PREAMBLE, data_in};
      par_n   = ^data_in;
      mode_n  = mode;
    end else if (sym_end) begin
      cnt_n = last ? '0 : cnt + 1'b1;
      sh_n  = sh << 1;
      if (last) begin
        state_n = state == PRE ? DATA : state == DATA ? PAR : (state == PAR && GAP_BITS > 0) ? GAP : IDLE;
        done_n  = state_n == IDLE;
      end
    end
    bit_n = state_n == PAR ? par_n : sh_n[SR-1];
    lvl_n = (state_n == PRE || state_n == DATA || state_n == PAR) && (bit_n ^ (mode_n == MODE_MAN && second_n));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      par     <= 1'b0;
      mode_q  <= MODE_NRZ;
      done    <= 1'b0;
      ant_out <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      par     <= par_n;
      mode_q  <= mode_n;
      done    <= done_n;
      ant_out <= car_n;
    end
  end
endmodule

// File: tb/tb_ook_frame_tx.sv
// tb_ook_frame_tx: frame-level model checks two transmitters (baseband and CARRIER_DIV=1) every cycle
module tb_ook_frame_tx;
  localparam int DW = 8, PW = 4, BC = 4, GB = 2, NS = PW + DW + 1 + GB, NC = NS * BC;
  logic clk = 1'b0, rst = 1'b1, data_valid = 1'b0, mode = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic rdy0, busy0, done0, ant0, rdy1, busy1, done1, ant1;
  logic [PW-1:0] pre_v = 4'hA;
  int passed = 0, total = 0;
  int pos = -1, cyc = 0, acc_cyc = 0, done_seen = 0;
  bit m_done = 1'b0;
  bit e0[NC], e1[NC];
  logic cap0[NC], cap1[NC];

  ook_frame_tx #(.DATA_W(DW), .PRE_W(PW), .PREAMBLE(4'hA), .BIT_CYCLES(BC), .GAP_BITS(GB), .CARRIER_DIV(0)) dut (
    .clk(clk), .reset(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy0),
    .mode(mode), .busy(busy0), .done(done0), .ant_out(ant0));
  ook_frame_tx #(.DATA_W(DW), .PRE_W(PW), .PREAMBLE(4'hA), .BIT_CYCLES(BC), .GAP_BITS(GB), .CARRIER_DIV(1)) dut_c (
    .clk(clk), .reset(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy1),
    .mode(mode), .busy(busy1), .done(done1), .ant_out(ant1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit sym_bit(input logic [DW-1:0] d, input int s);
    if (s < PW) return pre_v[PW-1-s];
    if (s < PW + DW) return d[DW-1-(s-PW)];
    if (s == PW + DW) return ^d;
    return 1'b0;
  endfunction

  // Expected antenna waveform for a whole frame, from the symbol list and coding rules
  function automatic void build(input logic [DW-1:0] d, input logic m);
    int run = 0;
    for (int t = 0; t < NC; t++) begin
      bit lv;
      lv = (t / BC < PW + DW + 1) && (sym_bit(d, t / BC) ^ (m && (t % BC) >= BC / 2));
      e0[t] = lv;
      e1[t] = lv && (run % 2 == 0);
      run = lv ? run + 1 : 0;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (rst) pos = -1;
    else if (pos < 0) begin
      if (data_valid) begin
        build(data_in, mode);
        pos = 0;
        acc_cyc = cyc - 1;
      end
    end else if (pos == NC - 1) begin
      pos = -1;
      m_done = 1'b1;
    end else pos++;
  end

  always @(posedge clk) begin
    #1;
    chk("ready", rdy0, pos < 0);
    chk("busy", busy0, pos >= 0);
    chk("done", done0, m_done);
    chk("ant", ant0, pos >= 0 ? e0[pos] : 1'b0);
    chk("ready_c", rdy1, pos < 0);
    chk("busy_c", busy1, pos >= 0);
    chk("done_c", done1, m_done);
    chk("ant_c", ant1, pos >= 0 ? e1[pos] : 1'b0);
    if (pos >= 0) begin
      cap0[pos] = ant0;
      cap1[pos] = ant1;
    end
    if (done0) done_seen = cyc;
  end

  task automatic send(input logic [DW-1:0] d, input logic m);
    bit ok = 1'b0;
    @(negedge clk);
    data_in = d;
    mode = m;
    data_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    data_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL accept_wait: ready never seen");
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = done0;
    end
    if (!ok) begin
      total++;
      $display("FAIL done_wait: no done pulse");
    end
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < 200 && pos != p; k++) @(negedge clk);
  endtask

  task automatic chk_nrz(input string name, input bit which, input logic [NS-1:0] pat);
    for (int t = 0; t < NC; t++)
      chk(name, which ? cap1[t] : cap0[t], pat[NS-1-t/BC] && (!which || t % 2 == 0));
  endtask

  initial begin
    logic [3:0] code;
    logic [NS-1:0] pat;
    int d1;
    repeat (2) @(negedge clk);
    chk("reset_ready", rdy0, 1'b1);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_done", done0, 1'b0);
    chk("reset_ant", ant0, 1'b0);
    rst = 1'b0;
    // 1: NRZ frame and completion latency
    send(8'hC3, 1'b0);
    wait_done();
    chk_int("done_latency", done_seen - acc_cyc, 61);
    chk_nrz("t1_nrz", 1'b0, 15'b1010_11000011_0_00);
    // 2: Manchester coding
    send(8'h01, 1'b1);
    wait_done();
    pat = 15'b1010_00000001_1_00;
    for (int t = 0; t < NC; t++) begin
      code = t / BC >= PW + DW + 1 ? 4'b0000 : pat[NS-1-t/BC] ? 4'b1100 : 4'b0011;
      chk("t2_man", cap0[t], code[3 - t % BC]);
    end
    // 3: valid held high, second word taken on the done cycle
    @(negedge clk);
    data_in = 8'hFF;
    mode = 1'b0;
    data_valid = 1'b1;
    wait_pos(0);
    @(negedge clk);
    data_in = 8'h00;
    wait_done();
    d1 = done_seen;
    chk("t3_par1", cap0[(PW + DW) * BC], 1'b0);
    @(negedge clk);
    chk("t3_b2b_busy", busy0, 1'b1);
    chk_int("t3_b2b_gap", acc_cyc, d1);
    data_valid = 1'b0;
    wait_done();
    chk_nrz("t3_second", 1'b0, 15'b1010_00000000_0_00);
    // 4: reset in the third payload symbol
    send(8'h55, 1'b0);
    wait_pos((PW + 2) * BC + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_ant", ant0, 1'b0);
    chk("t4_busy", busy0, 1'b0);
    chk("t4_ready", rdy0, 1'b1);
    chk("t4_done", done0, 1'b0);
    send(8'h3C, 1'b0);
    wait_done();
    chk_nrz("t4_after", 1'b0, 15'b1010_00111100_0_00);
    // 5: carrier on the CARRIER_DIV=1 instance
    send(8'h80, 1'b0);
    wait_done();
    chk_nrz("t5_carrier", 1'b1, 15'b1010_10000000_1_00);
    // 6: mid-frame input changes ignored
    send(8'h96, 1'b0);
    wait_pos(10 * BC);
    @(negedge clk);
    data_in = 8'hFF;
    mode = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready", rdy0, 1'b0);
    data_valid = 1'b0;
    wait_done();
    chk_nrz("t6_frame", 1'b0, 15'b1010_10010110_0_00);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
